// File: rtl/result_wb_arbiter.sv
// result_wb_arbiter: buffers four PE result streams in per-channel FIFOs and
// drains them round-robin onto a single ready/valid output-memory write port.
module result_wb_arbiter #(
   parameter int NUM_CH     = 4,
   parameter int FIFO_DEPTH = 2,
   parameter int ADDR_W     = 12,
   parameter int ELEM_W     = 12
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic signed [NUM_CH-1:0][5:0][5:0][ELEM_W-1:0] result_tile_i,
   input  logic [NUM_CH-1:0][ADDR_W-1:0]                result_address_i,
   input  logic [NUM_CH-1:0]                            result_valid_i,
   input  logic                                         clear_i,
   input  logic                                         mem_ready_i,
   output logic                                         mem_wen_o,
   output logic [ADDR_W-1:0]                            mem_addr_o,
   output logic [36*ELEM_W-1:0]                         mem_wdata_o,
   output logic [$clog2(NUM_CH)-1:0]                    mem_ch_o,
   output logic [NUM_CH-1:0]                            overflow_o,
   output logic [15:0]                                  wr_count_o,
   output logic                                         idle_o
);
   localparam int CW = $clog2(NUM_CH);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int DW = 36*ELEM_W;
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_STALL} state_t;

   logic [ADDR_W-1:0] r_faddr [NUM_CH][FIFO_DEPTH];
   logic [DW-1:0]     r_fdata [NUM_CH][FIFO_DEPTH];
   logic [PW-1:0]     r_wptr  [NUM_CH];
   logic [PW-1:0]     r_rptr  [NUM_CH];
   logic [PW:0]       r_cnt   [NUM_CH];
   logic [PW:0]       w_cnt_nxt [NUM_CH];
   logic              r_wen;
   logic [ADDR_W-1:0] r_addr;
   logic [DW-1:0]     r_data;
   logic [CW-1:0]     r_ch;
   logic [CW-1:0]     r_rr;
   logic [NUM_CH-1:0] r_ovf;
   logic [15:0]       r_wcnt;
   state_t            r_state;
   logic              w_load, w_xfer, w_gnt_vld, w_wen_nxt, w_busy_nxt;
   logic [CW-1:0]     w_gnt, w_idx;
   logic [NUM_CH-1:0] w_push, w_pop, w_full, w_ovf;

   always_comb begin
      w_load    = !r_wen || mem_ready_i;
      w_xfer    = r_wen && mem_ready_i;
      w_gnt     = '0;
      w_gnt_vld = 1'b0;
      w_idx     = '0;
      // scanning downward lets the channel closest to r_rr win
      for (int i = NUM_CH-1; i >= 0; i--) begin
         w_idx = CW'((int'(r_rr) + i) % NUM_CH);
         if (r_cnt[w_idx] != '0) begin
            w_gnt     = w_idx;
            w_gnt_vld = 1'b1;
         end
      end
      w_wen_nxt  = (w_load && w_gnt_vld) || (r_wen && !mem_ready_i);
      w_busy_nxt = w_wen_nxt;
      for (int k = 0; k < NUM_CH; k++) begin
         w_pop[k]     = w_load && w_gnt_vld && (w_gnt == CW'(k));
         w_full[k]    = r_cnt[k] == (PW+1)'(FIFO_DEPTH);
         w_push[k]    = result_valid_i[k] && (!w_full[k] || w_pop[k]);
         w_ovf[k]     = result_valid_i[k] && w_full[k] && !w_pop[k];
         w_cnt_nxt[k] = r_cnt[k] + (PW+1)'(w_push[k]) - (PW+1)'(w_pop[k]);
         w_busy_nxt   = w_busy_nxt || (w_cnt_nxt[k] != '0);
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_CH; k++) begin
         if (w_push[k]) begin
            r_faddr[k][r_wptr[k]] <= result_address_i[k];
            r_fdata[k][r_wptr[k]] <= result_tile_i[k];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < NUM_CH; k++) begin
            r_cnt[k]  <= '0;
            r_wptr[k] <= '0;
            r_rptr[k] <= '0;
         end
         r_wen   <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_ch    <= '0;
         r_rr    <= '0;
         r_ovf   <= '0;
         r_wcnt  <= '0;
         r_state <= S_IDLE;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            r_cnt[k] <= w_cnt_nxt[k];
            if (w_push[k]) r_wptr[k] <= r_wptr[k] + PW'(1);
            if (w_pop[k])  r_rptr[k] <= r_rptr[k] + PW'(1);
         end
         if (w_load && w_gnt_vld) begin
            r_wen  <= 1'b1;
            r_addr <= r_faddr[w_gnt][r_rptr[w_gnt]];
            r_data <= r_fdata[w_gnt][r_rptr[w_gnt]];
            r_ch   <= w_gnt;
            r_rr   <= CW'((int'(w_gnt) + 1) % NUM_CH);
         end else if (w_xfer) begin
            r_wen <= 1'b0;
         end
         r_ovf   <= clear_i ? '0 : (r_ovf | w_ovf);
         r_wcnt  <= clear_i ? '0 : r_wcnt + 16'(w_xfer);
         r_state <= !w_busy_nxt ? S_IDLE : (r_wen && !mem_ready_i && w_wen_nxt) ? S_STALL : S_BUSY;
      end
   end

   assign mem_wen_o   = r_wen;
   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_data;
   assign mem_ch_o    = r_ch;
   assign overflow_o  = r_ovf;
   assign wr_count_o  = r_wcnt;
   assign idle_o      = r_state == S_IDLE;
endmodule

// File: doc/result_wb_arbiter.md
# result_wb_arbiter

Writeback scheduler between the 2x2 PE array and the output memory. It buffers the four independent PE result streams (tile, address, valid) in per-channel FIFOs. It arbitrates them round-robin onto a single output-memory write port with ready/valid backpressure. It reports per-channel overflow and an idle flag that the main controller uses to qualify `conv_completed`.

## Interface
Parameters:
- `NUM_CH`, 4: number of PE result channels; channel k maps to `pe_k`.
- `FIFO_DEPTH`, 2: entries per channel FIFO; power of two, at least 2.
- `ADDR_W`, 12: result address width.
- `ELEM_W`, 12: signed result element width.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `result_tile_i`, in, `NUM_CH` x [5:0][5:0] x `ELEM_W` signed: result tiles from the PEs.
- `result_address_i`, in, `NUM_CH` x `ADDR_W`: destination address per channel.
- `result_valid_i`, in, `NUM_CH`: one-cycle valid per result tile; the PEs cannot be stalled.
- `clear_i`, in, 1: synchronous clear of `overflow_o` and `wr_count_o`.
- `mem_ready_i`, in, 1: output memory accepts the write this cycle.
- `mem_wen_o`, out, 1: write request valid.
- `mem_addr_o`, out, `ADDR_W`: write address.
- `mem_wdata_o`, out, 36*`ELEM_W` (432): packed tile; element [r][c] sits at bits (r*6+c)*`ELEM_W` +: `ELEM_W`.
- `mem_ch_o`, out, 2: source channel of the current write.
- `overflow_o`, out, `NUM_CH`: sticky flag; a result was dropped on that channel.
- `wr_count_o`, out, 16: count of completed writes; wraps at 2^16.
- `idle_o`, out, 1: all FIFOs are empty and no write is pending.

## Operation
- **Per-channel FIFO push.** A push happens when `result_valid_i[k]` is high and FIFO k is not full. A pop in the same cycle frees a slot, so a push into a full FIFO that is also being popped is accepted.
- **Overflow.** When `result_valid_i[k]` is high, FIFO k is full and FIFO k is not popped that cycle, the tile is dropped and `overflow_o[k]` is set. The flag stays set until `clear_i` or reset.
- **Output register.** One entry holds addr, data and channel; `mem_wen_o` reflects that it is full.
  - Transfer occurs when `mem_wen_o && mem_ready_i`.
  - The register may load a new entry in the same cycle it transfers, or whenever it is empty.
- **Arbiter.** Round-robin pointer `rr_ptr`, 2 bits, reset to 0.
  - When the output register can load, the arbiter scans channels `rr_ptr`, `rr_ptr+1`, … (mod 4) and grants the first non-empty FIFO.
  - On a grant it pops that FIFO and sets `rr_ptr` to grant+1 (mod 4).
  - With no grant, `rr_ptr` is unchanged.
- **Internal states.** IDLE (nothing buffered), BUSY (some FIFO non-empty or register full), STALL (register full and `mem_ready_i` low).
  - `idle_o` is high only in IDLE.
  - A push in the current cycle does not lower `idle_o` until the next cycle.
- **`wr_count_o`.** Increments by 1 per completed transfer.
  - `clear_i` has priority: a transfer in the same cycle as `clear_i` leaves the count at 0.
  - A push overflowing in the same cycle as `clear_i` leaves `overflow_o` at 0.
- **`clear_i` scope.** It does not flush the FIFOs or the output register.
- **Data integrity.** Address and data pass through unmodified: no arithmetic and no sign change.

## Timing
- **Reset.** While `reset` is low:
  - `mem_wen_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `mem_ch_o`=0;
  - `overflow_o`=0, `wr_count_o`=0, `idle_o`=1;
  - FIFOs empty, `rr_ptr`=0.
- **Reset mid-operation.** All buffered results are discarded and nothing is written afterwards.
- **Latency.** Valid at cycle N into an idle block produces `mem_wen_o`=1 at cycle N+2 (FIFO write at edge N, grant/load at edge N+1). There is no combinational bypass from input to memory port.
- **Throughput.** One write per cycle while `mem_ready_i`=1.
- **Handshake.** `mem_addr_o`, `mem_wdata_o` and `mem_ch_o` are held stable while `mem_wen_o`=1 and `mem_ready_i`=0.
- **Buffering limit.** With ready held low, a channel absorbs FIFO_DEPTH+1 results (FIFO plus output register, when that channel won the register).

## Test plan
- **Single result.** ch2 valid at cycle 0, addr 0x0A5, element [5][5]=-1; `mem_ready_i`=1.
  - Expect `mem_wen_o` at cycle 2 with addr 0x0A5, `mem_ch_o`=2, data bits [431:420]=0xFFF.
  - Expect `wr_count_o`=1 at cycle 3 and `idle_o`=1 at cycle 3.
- **Round-robin order.** All four channels valid at cycle 0; ready=1.
  - Expect writes from ch0, 1, 2, 3 on cycles 2, 3, 4, 5.
  - A second burst of all four at cycle 10 is also served 0, 1, 2, 3 (`rr_ptr`=0 after ch3).
- **Backpressure.** ch1 valid with A at cycle 0 and B at cycle 1; ready low during cycles 2–4.
  - Expect A held stable on cycles 2–4, A written at cycle 5, B written at cycle 6; no overflow.
- **Overflow.** ch0 valid A, B, C, D on cycles 0–3 with ready low throughout.
  - Expect `overflow_o`=4'b0001 from cycle 4.
  - After ready rises, exactly A, B, C are written in order; D is never written.
- **Fairness.** ch0 and ch3 valid every other cycle, ready=1 for 20 cycles.
  - Writes alternate between channels; no overflow.
  - `wr_count_o` equals the number of pushes, and `idle_o` rises two cycles after the last push.
- **Clear and reset mid-operation.**
  - `clear_i` pulsed during an active write: `wr_count_o`=0 and `overflow_o`=0 next cycle, pending writes still complete.
  - `reset` pulled low while 3 entries are buffered: all outputs return to reset values at once, no further writes occur, `idle_o`=1.
